// File: rtl/frame_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_pkg
//  Description : Shared defaults for the decimated frame geometry, pixel and
//                frame-buffer address widths, and the streaming FSM state
//                encoding. Shared by the decimation stage and the streamer.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_stream_pkg;

  localparam int DEF_IMG_W  = 40;  // decimated image width in pixels
  localparam int DEF_IMG_H  = 30;  // decimated image height in pixels
  localparam int DEF_PIX_W  = 8;   // pixel width in bits
  localparam int DEF_ADDR_W = 11;  // frame-buffer address width

  // Number of side-band flag bits carried with each pixel: sof, eol, eof.
  localparam int FLAG_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fs_state_t;

endpackage
`default_nettype wire

// File: rtl/pix_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : pix_fifo2
//  Description : Two-entry FIFO with fall-through. A word pushed into an
//                empty FIFO is visible on the output in the same cycle, so
//                the one-cycle frame-buffer read latency adds no extra delay.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                push, push_data     - write strobe / word (pixel + flags)
//                pop                 - consume head (only when out_valid)
//                out_valid, out_data - head word valid / head word
//                count               - number of stored entries (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_fifo2 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] store [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         bypass;
  logic         wr_en;
  logic         rd_en;

  // An empty FIFO receiving a word that is consumed in the same cycle never
  // stores it. The producer guarantees push never hits a full FIFO.
  assign bypass    = push && pop && (count == 2'd0);
  assign wr_en     = push && !bypass;
  assign rd_en     = pop && (count != 2'd0);

  assign out_valid = (count != 2'd0) || push;
  assign out_data  = (count != 2'd0) ? store[rd_ptr] : push_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store[0] <= '0;
      store[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (wr_en) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_stream_out.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_out
//  Description : Reads one decimated frame from the frame buffer in raster
//                order and streams it out on a valid/ready interface with
//                start-of-frame, end-of-line and end-of-frame flags.
//  Ports       : clk, rst_n               - clock, async active-low reset
//                start                    - pulse: stream one frame
//                mem_addr, mem_rd         - frame-buffer read address / enable
//                mem_rdata                - read data, 1 cycle after mem_rd
//                m_valid, m_ready, m_data - output pixel stream
//                m_sof, m_eol, m_eof      - frame / row / frame-end flags
//                busy, done               - frame in progress / end pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_stream_out
  import frame_stream_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = PIX_W + FLAG_W;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  fs_state_t         state;
  fs_state_t         state_nx;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              rd_q;      // a read is in flight this cycle
  logic [FLAG_W-1:0] flags_q;   // {sof, eol, eof} of the in-flight read
  logic              last_issue;
  logic              pop;
  logic [2:0]        level;
  logic              f_valid;
  logic [FW-1:0]     f_data;
  logic [1:0]        f_count;

  assign last_issue = (col == COL_LAST) && (row == ROW_LAST);
  assign pop        = f_valid && m_ready;

  // Entries that remain after this cycle's pop plus the read landing now.
  // Issuing a new read only while this is below 2 keeps every returning
  // datum within the FIFO while still sustaining one pixel per cycle.
  assign level = {1'b0, f_count} + {2'b00, rd_q} - {2'b00, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    mem_rd   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        mem_rd = (level < 3'd2);
        if (mem_rd && last_issue) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        // f_data[0] is the eof flag of the head pixel.
        if (pop && f_data[0]) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      mem_addr <= '0;
      rd_q     <= 1'b0;
      flags_q  <= '0;
      done     <= 1'b0;
    end else begin
      rd_q <= mem_rd;
      done <= pop && f_data[0];
      if (mem_rd) begin
        flags_q <= {(col == '0) && (row == '0), col == COL_LAST, last_issue};
        if (last_issue) begin
          // Counters return to the origin, ready for the next frame.
          col      <= '0;
          row      <= '0;
          mem_addr <= '0;
        end else begin
          mem_addr <= mem_addr + 1'b1;
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  pix_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_q),
    .push_data ({mem_rdata, flags_q}),
    .pop       (pop),
    .out_valid (f_valid),
    .out_data  (f_data),
    .count     (f_count)
  );

  assign busy    = (state != ST_IDLE);
  assign m_valid = f_valid;
  // Payload is forced to zero whenever nothing valid is presented.
  assign {m_data, m_sof, m_eol, m_eof} = f_valid ? f_data : '0;

endmodule
`default_nettype wire
